// File: rtl/lockstep_compare_monitor.sv
`default_nettype none
// ============================================================================
// Module   : lockstep_compare_monitor
// Purpose  : Skew-tolerant lockstep checker. Each lane has its own FIFO, and
//            aligned pairs are compared with sticky error and first-fail capture.
// Revision : 1.0  initial release
// ============================================================================
module lockstep_compare_monitor #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_enable,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_valid,
    output logic             match_valid,
    output logic             mismatch,
    output logic             err_sticky,
    output logic [CNT_W-1:0] compare_count,
    output logic [CNT_W-1:0] mismatch_count,
    output logic [WIDTH-1:0] first_a,
    output logic [WIDTH-1:0] first_b,
    output logic [CNT_W-1:0] first_index,
    output logic             overflow
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_OCC_W = c_PTR_W + 1;
    localparam logic [c_OCC_W-1:0] c_FULL = c_OCC_W'(DEPTH);

    logic [WIDTH-1:0]   r_mem_a [DEPTH];
    logic [WIDTH-1:0]   r_mem_b [DEPTH];
    logic [c_PTR_W-1:0] r_wr_a, r_rd_a, r_wr_b, r_rd_b;
    logic [c_OCC_W-1:0] r_occ_a, r_occ_b;

    logic               r_match_valid, r_mismatch, r_err_sticky, r_overflow;
    logic [CNT_W-1:0]   r_compare_count, r_mismatch_count, r_first_index;
    logic [WIDTH-1:0]   r_first_a, r_first_b;

    logic               w_pop, w_push_a, w_push_b, w_drop, w_diff, w_first;
    logic [WIDTH-1:0]   w_head_a, w_head_b;

    // Pop is decided on occupancy at the start of the cycle, so a sample
    // pushed into an empty FIFO always waits one edge before it can pop.
    assign w_pop    = clk_enable && (r_occ_a != '0) && (r_occ_b != '0);
    assign w_push_a = clk_enable && a_valid && ((r_occ_a != c_FULL) || w_pop);
    assign w_push_b = clk_enable && b_valid && ((r_occ_b != c_FULL) || w_pop);
    assign w_drop   = clk_enable && ((a_valid && !w_push_a) || (b_valid && !w_push_b));
    assign w_head_a = r_mem_a[r_rd_a];
    assign w_head_b = r_mem_b[r_rd_b];
    assign w_diff   = (w_head_a != w_head_b);
    assign w_first  = w_pop && w_diff && !r_err_sticky;

    // Storage needs no reset; pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (w_push_a) r_mem_a[r_wr_a] <= a_data;
        if (w_push_b) r_mem_b[r_wr_b] <= b_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_a  <= '0;
            r_rd_a  <= '0;
            r_occ_a <= '0;
            r_wr_b  <= '0;
            r_rd_b  <= '0;
            r_occ_b <= '0;
        end else begin
            if (w_push_a) r_wr_a <= r_wr_a + 1'b1;
            if (w_push_b) r_wr_b <= r_wr_b + 1'b1;
            if (w_pop) begin
                r_rd_a <= r_rd_a + 1'b1;
                r_rd_b <= r_rd_b + 1'b1;
            end
            case ({w_push_a, w_pop})
                2'b10:   r_occ_a <= r_occ_a + 1'b1;
                2'b01:   r_occ_a <= r_occ_a - 1'b1;
                default: r_occ_a <= r_occ_a;
            endcase
            case ({w_push_b, w_pop})
                2'b10:   r_occ_b <= r_occ_b + 1'b1;
                2'b01:   r_occ_b <= r_occ_b - 1'b1;
                default: r_occ_b <= r_occ_b;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_match_valid    <= 1'b0;
            r_mismatch       <= 1'b0;
            r_err_sticky     <= 1'b0;
            r_overflow       <= 1'b0;
            r_compare_count  <= '0;
            r_mismatch_count <= '0;
            r_first_a        <= '0;
            r_first_b        <= '0;
            r_first_index    <= '0;
        end else begin
            // Pulses drop to zero on disabled edges too, so none can repeat.
            r_match_valid <= w_pop;
            r_mismatch    <= w_pop && w_diff;
            if (w_drop) r_overflow <= 1'b1;
            if (w_pop && (r_compare_count != '1))
                r_compare_count <= r_compare_count + 1'b1;
            if (w_pop && w_diff) begin
                r_err_sticky <= 1'b1;
                if (r_mismatch_count != '1)
                    r_mismatch_count <= r_mismatch_count + 1'b1;
            end
            if (w_first) begin
                r_first_a     <= w_head_a;
                r_first_b     <= w_head_b;
                r_first_index <= r_compare_count;
            end
        end
    end

    assign match_valid    = r_match_valid;
    assign mismatch       = r_mismatch;
    assign err_sticky     = r_err_sticky;
    assign overflow       = r_overflow;
    assign compare_count  = r_compare_count;
    assign mismatch_count = r_mismatch_count;
    assign first_a        = r_first_a;
    assign first_b        = r_first_b;
    assign first_index    = r_first_index;

endmodule
`default_nettype wire
